// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: fetch-stage branch predictor for the RV32I pipeline.
// A direct-mapped tagged BTB whose index is the fetch PC hashed with global
// history. Each entry holds a saturating direction counter. Lookup is purely
// combinational. Training happens on the EX-stage resolution port.
// Optional feature macro GSHARE_RAS_EN adds a return address stack that is
// driven from fetch-time call/return decode (RAS_DEPTH must be >= 2).
module gshare_btb_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_W       = 6,
    parameter int CTR_W       = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_IF_i,
    input  logic [31:0] instr_IF_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_is_jump_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    // Counter training: a miss restarts at the weak state matching the outcome,
    // a hit moves one step toward the outcome and clamps at either end.
    function automatic logic [CTR_W-1:0] ctr_next(input logic hit,
                                                  input logic [CTR_W-1:0] c,
                                                  input logic taken);
        if (!hit)  return taken ? CTR_WT : CTR_WNT;
        if (taken) return (c == CTR_MAX) ? c : c + CTR_W'(1);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    // Shift the newest outcome into the history register (works for GHR_W=1).
    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] g,
                                                   input logic t);
        logic [GHR_W:0] s;
        s = {g, t};
        return s[GHR_W-1:0];
    endfunction

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] is_jump_q;
    logic [CTR_W-1:0]       ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [GHR_W-1:0]       ghr_q;

    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, btb_taken;
    logic [31:0]      pc_plus4;
    logic             ras_pop;
    logic [31:0]      ras_top;
    logic             unused_bits;

    assign ghr_ext   = IDX_W'(ghr_q);
    assign lk_idx    = pc_IF_i[IDX_W+1:2] ^ ghr_ext;
    assign lk_tag    = pc_IF_i[31:IDX_W+2];
    assign up_idx    = upd_pc_i[IDX_W+1:2] ^ ghr_ext;
    assign up_tag    = upd_pc_i[31:IDX_W+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign btb_taken = lk_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][CTR_W-1]);
    assign pc_plus4  = pc_IF_i + 32'd4;

    // Reset forces the cold prediction at once, even before any clock edge.
    assign pred_taken_o = rst_ni && (ras_pop || btb_taken);
    assign pred_pc_o    = !pred_taken_o ? pc_plus4 :
                          ras_pop       ? ras_top  : target_q[lk_idx];

    // Control state: valid bits, direction counters and non-speculative history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ghr_q   <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= CTR_WNT;
        end else if (upd_valid_i) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_next(up_hit, ctr_q[up_idx], upd_taken_i);
            if (!upd_is_jump_i) ghr_q <= ghr_shift(ghr_q, upd_taken_i);
        end
    end

    // Entry payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (upd_valid_i) begin
            tag_q[up_idx]     <= up_tag;
            is_jump_q[up_idx] <= upd_is_jump_i;
            if (upd_taken_i) target_q[up_idx] <= upd_target_i;
        end
    end

`ifdef GSHARE_RAS_EN
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic [31:0]      ras_q [RAS_DEPTH];
    logic [RAS_W-1:0] ras_ptr_q;
    logic [31:0]      prev_pc_q;
    logic             prev_vld_q;
    logic [4:0]       rd, rs1;
    logic             is_jal, is_jalr, rd_link, rs1_link, is_call, fetch_new;

    assign rd        = instr_IF_i[11:7];
    assign rs1       = instr_IF_i[19:15];
    assign is_jal    = instr_IF_i[6:0] == 7'h6F;
    assign is_jalr   = (instr_IF_i[6:0] == 7'h67) && (instr_IF_i[14:12] == 3'b000);
    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign is_call   = (is_jal || is_jalr) && rd_link;
    // Plain return, or a jalr linking through the other link register (pop+push).
    assign ras_pop   = is_jalr && rs1_link &&
                       (((rd == 5'd0) && (instr_IF_i[31:20] == 12'd0)) ||
                        (rd_link && (rd != rs1)));
    assign ras_top   = ras_q[ras_ptr_q];
    // A held fetch PC is a stall; it must not push or pop a second time.
    assign fetch_new = !prev_vld_q || (pc_IF_i != prev_pc_q);

    // Stack pointer and stall detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q  <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_pc_q  <= pc_IF_i;
            prev_vld_q <= 1'b1;
            if (fetch_new) begin
                if (ras_pop && !is_call)      ras_ptr_q <= ras_ptr_q - RAS_W'(1);
                else if (is_call && !ras_pop) ras_ptr_q <= ras_ptr_q + RAS_W'(1);
            end
        end
    end

    // Return addresses: a combined pop+push overwrites the current top in place.
    always_ff @(posedge clk_i) begin
        if (fetch_new && is_call) begin
            if (ras_pop) ras_q[ras_ptr_q]              <= pc_plus4;
            else         ras_q[ras_ptr_q + RAS_W'(1)] <= pc_plus4;
        end
    end

    assign unused_bits = ^upd_pc_i[1:0];
`else
    assign ras_pop     = 1'b0;
    assign ras_top     = '0;
    assign unused_bits = ^{upd_pc_i[1:0], instr_IF_i, RAS_DEPTH[0]};
`endif

endmodule
